// File: rtl/gpu_csr_ctrl.sv
// Avalon-MM CSR slave for the render core: shadow/active config,
// per-view camera sets and a start/done render sequencer with irq.
module gpu_csr_ctrl #(
    parameter logic [31:0] DEFAULT_BUFFER = 32'h0800_0000,
    parameter logic [15:0] H_RESOLUTION   = 16'd256,
    parameter logic [15:0] V_RESOLUTION   = 16'd192,
    parameter int          NUM_VIEWS      = 2,
    parameter int          FRAME_CNT_W    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               s1_address,
    input  logic                     s1_read,
    input  logic                     s1_write,
    input  logic [31:0]              s1_writedata,
    output logic [31:0]              s1_readdata,
    output logic                     s1_waitrequest,
    output logic                     core_start,
    input  logic                     core_done,
    output logic [31:0]              cfg_pixel_buffer,
    output logic [31:0]              cfg_voxel_buffer,
    output logic [31:0]              cfg_voxel_count,
    output logic [31:0]              cfg_palette_buffer,
    output logic [31:0]              cfg_palette_length,
    output logic [2:0]               cfg_view,
    output logic [NUM_VIEWS*480-1:0] cfg_cam,
    output logic                     irq
);
    localparam int NW = NUM_VIEWS * 15;
    localparam int CW = $clog2(NW);

    typedef enum logic [1:0] {IDLE, COMMIT, START, BUSY} state_t;

    state_t                   state_q, state_d;
    logic [31:0]              shd_q [5];
    logic [31:0]              shd_d [5];
    logic [31:0]              act_q [5];
    logic [31:0]              act_d [5];
    logic [31:0]              cam_q [NW];
    logic [31:0]              cam_d [NW];
    logic [NUM_VIEWS*480-1:0] cam_act_q, cam_act_d;
    logic                     irq_en_q, irq_en_d;
    logic [2:0]               view_sel_q, view_sel_d;
    logic [2:0]               view_act_q, view_act_d;
    logic                     start_pend_q, start_pend_d;
    logic                     irq_pend_q, irq_pend_d;
    logic                     overrun_q, overrun_d;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                     core_start_q, core_start_d;
    logic                     irq_q, irq_d;
    logic [31:0]              rdata_q, rdata_d;

    logic [7:0]    cam_off;
    logic [3:0]    cam_v, cam_i;
    logic          cam_hit;
    logic [CW-1:0] cam_idx;
    logic          wr_en, start_req, ctrl_clr;
    logic [31:0]   rd_val;

    assign s1_waitrequest = s1_write && (state_q == COMMIT);

    always_comb begin
        cam_off   = s1_address - 8'h10;
        cam_v     = cam_off[7:4];
        cam_i     = cam_off[3:0];
        cam_hit   = (s1_address >= 8'h10) && (cam_i != 4'hf)
                    && (int'(cam_v) < NUM_VIEWS);
        cam_idx   = CW'(int'(cam_v) * 15 + int'(cam_i));
        wr_en     = s1_write && !s1_waitrequest;
        start_req = wr_en && (s1_address == 8'h0f) && (s1_writedata != '0);
        ctrl_clr  = wr_en && (s1_address == 8'h0f) && (s1_writedata == '0);
    end

    always_comb begin
        rd_val = '0;
        if (cam_hit) begin
            rd_val = cam_q[cam_idx];
        end else if (s1_address < 8'h05) begin
            rd_val = shd_q[s1_address[2:0]];
        end else begin
            case (s1_address)
                8'h05: rd_val = {V_RESOLUTION, H_RESOLUTION};
                8'h06: rd_val = {31'd0, irq_en_q};
                8'h07: rd_val = {29'd0, view_sel_q};
                8'h08: rd_val = {16'd0, 8'(frame_cnt_q), 4'd0, overrun_q,
                                 start_pend_q, irq_pend_q, state_q != IDLE};
                default: rd_val = '0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        shd_d        = shd_q;
        act_d        = act_q;
        cam_d        = cam_q;
        cam_act_d    = cam_act_q;
        irq_en_d     = irq_en_q;
        view_sel_d   = view_sel_q;
        view_act_d   = view_act_q;
        start_pend_d = start_pend_q;
        irq_pend_d   = irq_pend_q;
        overrun_d    = overrun_q;
        frame_cnt_d  = frame_cnt_q;
        core_start_d = 1'b0;
        rdata_d      = s1_read ? rd_val : rdata_q;

        if (wr_en) begin
            if (cam_hit) begin
                cam_d[cam_idx] = s1_writedata;
            end else if (s1_address < 8'h05) begin
                shd_d[s1_address[2:0]] = s1_writedata;
            end else if (s1_address == 8'h06) begin
                irq_en_d = s1_writedata[0];
            end else if (s1_address == 8'h07
                         && s1_writedata < 32'(NUM_VIEWS)) begin
                view_sel_d = s1_writedata[2:0];
            end
        end

        if (ctrl_clr) begin
            irq_pend_d = 1'b0;
            overrun_d  = 1'b0;
        end

        // Only one start may queue behind the running frame.
        if (start_req && state_q != IDLE) begin
            if (start_pend_q) overrun_d = 1'b1;
            else              start_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: if (start_req) state_d = COMMIT;
            COMMIT: begin
                act_d        = shd_q;
                view_act_d   = view_sel_q;
                start_pend_d = 1'b0;
                core_start_d = 1'b1;
                state_d      = START;
                for (int k = 0; k < NW; k++) cam_act_d[k*32 +: 32] = cam_q[k];
            end
            START: state_d = BUSY;
            BUSY: begin
                if (core_done) begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    irq_pend_d  = 1'b1;
                    state_d     = (start_pend_q || start_req) ? COMMIT : IDLE;
                end
            end
        endcase

        irq_d = irq_pend_d && irq_en_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            for (int k = 0; k < 5; k++) begin
                shd_q[k] <= (k == 0) ? DEFAULT_BUFFER : '0;
                act_q[k] <= (k == 0) ? DEFAULT_BUFFER : '0;
            end
            for (int k = 0; k < NW; k++) cam_q[k] <= '0;
            cam_act_q    <= '0;
            irq_en_q     <= 1'b0;
            view_sel_q   <= '0;
            view_act_q   <= '0;
            start_pend_q <= 1'b0;
            irq_pend_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
            core_start_q <= 1'b0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            shd_q        <= shd_d;
            act_q        <= act_d;
            cam_q        <= cam_d;
            cam_act_q    <= cam_act_d;
            irq_en_q     <= irq_en_d;
            view_sel_q   <= view_sel_d;
            view_act_q   <= view_act_d;
            start_pend_q <= start_pend_d;
            irq_pend_q   <= irq_pend_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
            core_start_q <= core_start_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
        end
    end

    assign s1_readdata        = rdata_q;
    assign core_start         = core_start_q;
    assign irq                = irq_q;
    assign cfg_pixel_buffer   = act_q[0];
    assign cfg_voxel_buffer   = act_q[1];
    assign cfg_voxel_count    = act_q[2];
    assign cfg_palette_buffer = act_q[3];
    assign cfg_palette_length = act_q[4];
    assign cfg_view           = view_act_q;
    assign cfg_cam            = cam_act_q;
endmodule

// File: tb/tb_gpu_csr_ctrl.sv
// Randomized bench for gpu_csr_ctrl against a frame-level reference
// model of the register file and render sequencer.
module tb_gpu_csr_ctrl;
    localparam int NV = 2;
    localparam int P_IDLE = 0, P_COMMIT = 1, P_START = 2, P_RENDER = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        s1_address = '0;
    logic              s1_read = 1'b0;
    logic              s1_write = 1'b0;
    logic [31:0]       s1_writedata = '0;
    logic [31:0]       s1_readdata;
    logic              s1_waitrequest;
    logic              core_start;
    logic              core_done = 1'b0;
    logic [31:0]       cfg_pixel_buffer, cfg_voxel_buffer, cfg_voxel_count;
    logic [31:0]       cfg_palette_buffer, cfg_palette_length;
    logic [2:0]        cfg_view;
    logic [NV*480-1:0] cfg_cam;
    logic              irq;

    gpu_csr_ctrl #(.NUM_VIEWS(NV)) dut (
        .clock(clock), .reset(reset),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
        .s1_waitrequest(s1_waitrequest),
        .core_start(core_start), .core_done(core_done),
        .cfg_pixel_buffer(cfg_pixel_buffer),
        .cfg_voxel_buffer(cfg_voxel_buffer),
        .cfg_voxel_count(cfg_voxel_count),
        .cfg_palette_buffer(cfg_palette_buffer),
        .cfg_palette_length(cfg_palette_length),
        .cfg_view(cfg_view), .cfg_cam(cfg_cam), .irq(irq)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_shd [5];
    logic [31:0] m_act [5];
    logic [31:0] m_cam [NV][15];
    logic [31:0] m_cam_act [NV][15];
    bit          m_en, m_spend, m_ipend, m_ovr, m_start, m_irq;
    int          m_vsel, m_vact, m_phase;
    logic [7:0]  m_fc;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_shd[k] = (k == 0) ? 32'h0800_0000 : 32'h0;
            m_act[k] = m_shd[k];
        end
        for (int v = 0; v < NV; v++)
            for (int i = 0; i < 15; i++) begin
                m_cam[v][i] = 0;
                m_cam_act[v][i] = 0;
            end
        m_en = 0; m_spend = 0; m_ipend = 0; m_ovr = 0;
        m_start = 0; m_irq = 0;
        m_vsel = 0; m_vact = 0; m_phase = P_IDLE;
        m_fc = 0; m_rdata = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int v, i;
        if (a < 8'h05) return m_shd[a];
        if (a == 8'h05) return {16'd192, 16'd256};
        if (a == 8'h06) return {31'd0, m_en};
        if (a == 8'h07) return 32'(m_vsel);
        if (a == 8'h08)
            return {16'd0, m_fc, 4'd0, m_ovr, m_spend, m_ipend,
                    m_phase != P_IDLE};
        if (a < 8'h10) return 0;
        v = (int'(a) - 16) / 16;
        i = (int'(a) - 16) % 16;
        if (i < 15 && v < NV) return m_cam[v][i];
        return 0;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        int v, i;
        if (a < 8'h05) m_shd[a] = d;
        else if (a == 8'h06) m_en = d[0];
        else if (a == 8'h07) begin
            if (d < NV) m_vsel = int'(d);
        end else if (a >= 8'h10) begin
            v = (int'(a) - 16) / 16;
            i = (int'(a) - 16) % 16;
            if (i < 15 && v < NV) m_cam[v][i] = d;
        end
    endtask

    task automatic check_outputs();
        check("core_start", 32'(core_start), 32'(m_start));
        check("irq", 32'(irq), 32'(m_irq));
        check("readdata", s1_readdata, m_rdata);
        check("cfg_pixel", cfg_pixel_buffer, m_act[0]);
        check("cfg_voxel", cfg_voxel_buffer, m_act[1]);
        check("cfg_vcount", cfg_voxel_count, m_act[2]);
        check("cfg_pal", cfg_palette_buffer, m_act[3]);
        check("cfg_pallen", cfg_palette_length, m_act[4]);
        check("cfg_view", 32'(cfg_view), 32'(m_vact));
        for (int v = 0; v < NV; v++)
            for (int i = 0; i < 15; i++)
                check("cfg_cam", cfg_cam[(v*15+i)*32 +: 32], m_cam_act[v][i]);
    endtask

    task automatic do_reset();
        reset = 0;
        s1_read = 0; s1_write = 0; core_done = 0;
        @(negedge clock);
        @(negedge clock);
        model_reset();
        reset = 1;
        check("rst_wait", 32'(s1_waitrequest), 32'd0);
        check_outputs();
    endtask

    // One bus cycle: drive at negedge, advance model, compare next negedge.
    task automatic step(input logic [7:0] a, input bit r, input bit w,
                        input logic [31:0] d, input bit done,
                        output bit stalled);
        bit exp_wait, acc, st, clr, queued;
        s1_address = a; s1_read = r; s1_write = w;
        s1_writedata = d; core_done = done;
        exp_wait = w && (m_phase == P_COMMIT);
        #1 check("waitreq", 32'(s1_waitrequest), 32'(exp_wait));
        stalled = exp_wait;
        acc = w && !exp_wait;
        if (r) m_rdata = model_read(a);
        st  = acc && a == 8'h0f && d != 0;
        clr = acc && a == 8'h0f && d == 0;
        if (acc) model_write(a, d);
        if (clr) begin
            m_ipend = 0;
            m_ovr = 0;
        end
        queued = m_spend || st;
        if (st && m_phase != P_IDLE) begin
            if (m_spend) m_ovr = 1;
            else m_spend = 1;
        end
        m_start = 0;
        case (m_phase)
            P_IDLE: if (st) m_phase = P_COMMIT;
            P_COMMIT: begin
                m_act = m_shd;
                m_cam_act = m_cam;
                m_vact = m_vsel;
                m_spend = 0;
                m_start = 1;
                m_phase = P_START;
            end
            P_START: m_phase = P_RENDER;
            default: if (done) begin
                m_fc = m_fc + 8'd1;
                m_ipend = 1;
                m_phase = queued ? P_COMMIT : P_IDLE;
            end
        endcase
        m_irq = m_ipend && m_en;
        @(negedge clock);
        s1_read = 0; s1_write = 0; core_done = 0;
        check_outputs();
    endtask

    task automatic idle(input bit done);
        bit s;
        step(8'h00, 0, 0, 0, done, s);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bit s;
        step(a, 0, 1, d, 0, s);
    endtask

    task automatic rd(input logic [7:0] a);
        bit s;
        step(a, 1, 0, 0, 0, s);
    endtask

    initial begin
        bit          stalled;
        logic [7:0]  a;
        logic [31:0] d;
        bit          r, w, dn;
        int          kind, sel;

        do_reset();
        check("rst_rdata", s1_readdata, 32'h0);
        rd(8'h00); check("rd_pix", s1_readdata, 32'h0800_0000);
        rd(8'h05); check("rd_res", s1_readdata, 32'h00C0_0100);
        rd(8'h08); check("rd_status", s1_readdata, 32'h0);

        wr(8'h01, 32'h1234);
        wr(8'h0f, 32'h1);
        check("start_n1", 32'(core_start), 32'd0);
        idle(0);
        check("start_n2", 32'(core_start), 32'd1);
        check("vox_act", cfg_voxel_buffer, 32'h1234);
        rd(8'h08); check("busy", 32'(s1_readdata[0]), 32'd1);
        wr(8'h01, 32'h5678);
        check("vox_hold", cfg_voxel_buffer, 32'h1234);
        idle(1);
        check("irq_masked", 32'(irq), 32'd0);
        rd(8'h08); check("fc_one", s1_readdata, 32'h0000_0102);
        wr(8'h06, 32'h1); check("irq_en", 32'(irq), 32'd1);
        wr(8'h0f, 32'h0); check("irq_clr", 32'(irq), 32'd0);

        wr(8'h0f, 32'h1);
        idle(0);
        idle(0);
        wr(8'h0f, 32'h1);
        wr(8'h0f, 32'h1);
        rd(8'h08); check("pend_ovr", 32'(s1_readdata[3:2]), 32'd3);
        idle(1);
        rd(8'h08);
        check("restart", 32'(core_start), 32'd1);
        check("no_idle", 32'(s1_readdata[0]), 32'd1);
        check("vox_next", cfg_voxel_buffer, 32'h5678);
        idle(0);
        idle(1);

        wr(8'h23, 32'hABCD);
        wr(8'h07, 32'h1);
        wr(8'h0f, 32'h1);
        idle(0);
        check("cam_word", cfg_cam[18*32 +: 32], 32'hABCD);
        check("view_act", 32'(cfg_view), 32'd1);
        wr(8'h07, 32'(NV));
        rd(8'h07); check("view_keep", s1_readdata, 32'h1);
        idle(0);
        idle(1);

        wr(8'h0f, 32'h1);
        idle(0);
        idle(0);
        do_reset();
        idle(1);
        check("rst_nostart", 32'(core_start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rd(8'h08); check("rst_fc", s1_readdata, 32'h0);
        check("rst_nostart2", 32'(core_start), 32'd0);

        stalled = 0;
        a = 0; d = 0; r = 0; w = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!stalled) begin
                if ($urandom_range(0, 199) == 0) begin
                    do_reset();
                    continue;
                end
                kind = $urandom_range(0, 9);
                r = (kind <= 3);
                w = (kind >= 4 && kind <= 7);
                sel = $urandom_range(0, 5);
                case (sel)
                    0: a = 8'($urandom_range(0, 8));
                    1, 5: a = 8'h0f;
                    2: a = 8'(16 + 16 * $urandom_range(0, NV)
                              + $urandom_range(0, 15));
                    3: a = 8'($urandom_range(0, 255));
                    default: a = 8'h07;
                endcase
                if (a == 8'h07) d = $urandom_range(0, 3);
                else if (a == 8'h0f)
                    d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                else d = $urandom;
            end
            if (m_phase == P_RENDER) dn = ($urandom_range(0, 4) == 0);
            else dn = ($urandom_range(0, 30) == 0);
            step(a, r, w, d, dn, stalled);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gpu_csr_ctrl.md
Name: gpu_csr_ctrl

Overview:
Parametrised successor to the GPU register slave. It is an Avalon-MM CSR block with double-buffered (shadow/active) render configuration, multiple camera view sets and a render sequencer. The sequencer handshakes with the render core and owns a sticky, maskable completion interrupt. It sits between the HPS bridge and the render core and drives all configuration the core consumes.

Parameters:
DEFAULT_BUFFER, 32'h0800_0000, reset value of pixel_buffer (shadow and active)
H_RESOLUTION, 16'd256, horizontal resolution, read-only in RES register
V_RESOLUTION, 16'd192, vertical resolution, read-only in RES register
NUM_VIEWS, 2, number of camera sets (1..8), each 15 x 32-bit words
FRAME_CNT_W, 8, width of completed-frame counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
s1_address  in  8  word address
s1_read  in  1  read strobe
s1_write  in  1  write strobe
s1_writedata  in  32  write data
s1_readdata  out  32  read data, valid the cycle after accepted s1_read (fixed latency 1)
s1_waitrequest  out  1  stall; asserted only for writes during COMMIT
core_start  out  1  one-cycle render start pulse
core_done  in  1  one-cycle render-complete pulse from core
cfg_pixel_buffer, cfg_voxel_buffer, cfg_voxel_count, cfg_palette_buffer, cfg_palette_length  out  32 each  active config
cfg_view  out  3  active view index
cfg_cam  out  NUM_VIEWS*480  active camera words, view v word i at bits [(v*15+i)*32 +: 32]
irq  out  1  interrupt, level

Behaviour:
- Register map (word addr):
  - 0x00-0x04: pixel_buffer, voxel_buffer, voxel_count, palette_buffer, palette_length (shadow, RW).
  - 0x05: RES, RO, {V_RESOLUTION, H_RESOLUTION}.
  - 0x06: IRQ_EN, bit0, RW.
  - 0x07: VIEW_SEL, RW, [2:0]; writes with value >= NUM_VIEWS are ignored.
  - 0x08: STATUS, RO. bit0 busy (state != IDLE), bit1 irq_pending, bit2 start_pending, bit3 overrun (sticky), [15:8] frame_count.
  - 0x0f: CTRL. Write nonzero = start request. Write 0 = clear irq_pending and overrun.
  - 0x10 + 16*v + i (i 0..14, v < NUM_VIEWS): camera shadow word, order pos.xyz, look0..look3.xyz.
- Unmapped reads return 0; unmapped writes are ignored. Reads always return shadow values.
- Reset (reset==0 at edge):
  - Shadow and active pixel_buffer = DEFAULT_BUFFER; all other shadow/active/camera words = 0; IRQ_EN = 0; VIEW_SEL = 0.
  - state = IDLE; core_start, irq, s1_readdata, s1_waitrequest = 0.
  - start_pending, irq_pending, overrun, frame_count = 0.
  - Reset mid-render behaves identically: a later core_done is ignored because state is IDLE.
- FSM:
  - IDLE: start request -> COMMIT.
  - COMMIT (1 cycle): copy all shadow to active, clear start_pending, hold s1_waitrequest high if s1_write -> START.
  - START (1 cycle): core_start=1 -> BUSY.
  - BUSY: on core_done, frame_count++ (wraps), set irq_pending; then -> COMMIT if start_pending (or a start is written this cycle), else -> IDLE.
- Start latency: start written in IDLE at cycle N -> COMMIT at N+1, core_start high at N+2.
- Start request while not IDLE: sets start_pending. If start_pending is already set, the request is dropped and overrun is set.
- core_done outside BUSY: ignored.
- Same-cycle events:
  - core_done and CTRL=0 write: set wins, irq_pending=1.
  - Shadow write during BUSY: affects the next frame only; active config is stable for the whole render.
- irq = irq_pending & IRQ_EN, registered. Toggling IRQ_EN does not clear the pending bit.

Test Plan:
- Reset, then read 0x00, 0x05, 0x08 -> 0x0800_0000, 0x00C0_0100, 0x0 respectively.
- Write 0x01=0x1234, CTRL=1 at cycle N -> core_start high exactly at N+2; cfg_voxel_buffer=0x1234 from N+2; STATUS.busy=1.
- While BUSY write 0x01=0x5678 -> cfg_voxel_buffer stays 0x1234. core_done -> IDLE, frame_count=1, irq=0 with IRQ_EN=0. Set IRQ_EN=1 -> irq=1; CTRL=0 -> irq=0.
- Two starts while BUSY -> start_pending=1, overrun=1. core_done -> COMMIT with no IDLE cycle, second core_start, cfg_voxel_buffer=0x5678.
- Write camera addr 0x10+16+3 (view1 look0.x)=0xABCD, VIEW_SEL=1, start -> cfg_cam bits [(18)*32 +: 32]=0xABCD, cfg_view=1. VIEW_SEL=NUM_VIEWS write -> unchanged.
- Assert reset during BUSY, then pulse core_done -> state IDLE, frame_count=0, irq=0, no core_start.
